// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled 8N1-style UART receiver.
// The line is first passed through a 2-FF synchronizer. Each bit is the
// 3-sample majority vote around mid-bit, and a finished byte lands in a
// single-entry valid/ready holding register. rx_tick is a clock enable, not
// a clock.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_V0   = TW'(M - 1);
  localparam logic [TW-1:0] T_V1   = TW'(M);
  localparam logic [TW-1:0] T_V2   = TW'(M + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic                 sync1, rxs;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [2:0]           smp;
  logic [DATA_BITS-1:0] shreg;

  logic tick_last, tick_v2, s2_now, vote;
  logic shift_en, clr_bits, commit;

  assign tick_last = rx_tick && (tick_cnt == T_LAST);
  assign tick_v2   = rx_tick && (tick_cnt == T_V2);
  // The third vote sample is taken in the very cycle the stop bit commits,
  // so use the live line value on that tick instead of the stored one.
  assign s2_now    = tick_v2 ? rxs : smp[2];
  assign vote      = (smp[0] & smp[1]) | (smp[0] & s2_now) | (smp[1] & s2_now);
  assign busy      = (state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    clr_bits = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE:  if (!rxs) state_n = START;
      START: if (tick_last) begin
               if (vote) state_n = IDLE;   // glitch, not a real start bit
               else begin
                 state_n  = DATA;
                 clr_bits = 1'b1;
               end
             end
      DATA:  if (tick_last) begin
               shift_en = 1'b1;
               if (bit_cnt == B_LAST) state_n = STOP;
             end
      // Leave at mid-stop so the next start edge is never missed.
      STOP:  if (tick_v2) begin
               commit  = 1'b1;
               state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase
  end

  // Oversample phase counter; parked at 0 while idle.
  always_ff @(posedge sys_clk) begin
    if (rst || state == IDLE) tick_cnt <= '0;
    else if (rx_tick)         tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
  end

  // Capture the three mid-bit samples used by the majority vote.
  always_ff @(posedge sys_clk) begin
    if (rst) smp <= 3'b111;
    else if (rx_tick && state != IDLE) begin
      if (tick_cnt == T_V0) smp[0] <= rxs;
      if (tick_cnt == T_V1) smp[1] <= rxs;
      if (tick_cnt == T_V2) smp[2] <= rxs;
    end
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (clr_bits)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)      shreg   <= {vote, shreg[DATA_BITS-1:1]};
    end
  end

  // Holding register, framing error pulse and sticky overrun flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (commit) begin
        if (!vote)                      frame_err <= 1'b1;
        else if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else                        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
